// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - opcodes and result-bundle layout shared by execute_stage and memory_access
package execute_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 8;
  localparam int REG_W    = 4;
  localparam int OP_W     = 4;

  localparam int BUNDLE_W = 79;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 7;
  localparam int VAL_LSB  = 8;
  localparam int VAL_MSB  = 71;
  localparam int REG_LSB  = 72;
  localparam int REG_MSB  = 75;
  localparam int LOAD_BIT = 76;
  localparam int MEMW_BIT = 77;
  localparam int WR_BIT   = 78;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_AND   = 4'd3;
  localparam logic [OP_W-1:0] OP_OR    = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd7;
  localparam logic [OP_W-1:0] OP_SRA   = 4'd8;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd9;
  localparam logic [OP_W-1:0] OP_STORE = 4'd10;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd11;

  typedef logic [BUNDLE_W-1:0] bundle_t;

  // An all-zero bundle is the bubble that memory_access ignores.
  function automatic bundle_t pack_bundle(
    input logic              is_write,
    input logic              is_memw,
    input logic              is_load,
    input logic [REG_W-1:0]  reg_addr,
    input logic [DATA_W-1:0] value,
    input logic [ADDR_W-1:0] addr
  );
    bundle_t bnd;
    bnd                     = '0;
    bnd[ADDR_MSB:ADDR_LSB]  = addr;
    bnd[VAL_MSB:VAL_LSB]    = value;
    bnd[REG_MSB:REG_LSB]    = reg_addr;
    bnd[LOAD_BIT]           = is_load;
    bnd[MEMW_BIT]           = is_memw;
    bnd[WR_BIT]             = is_write;
    return bnd;
  endfunction

endpackage

// File: rtl/execute_if.sv
// rtl/execute_if.sv - decode-to-execute op handshake
interface execute_if;
  import execute_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  rd;

  modport master (
    output in_valid, op, a, b, imm, store_data, rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, a, b, imm, store_data, rd,
    output in_ready
  );
endinterface

// File: rtl/execute_mul_iter.sv
// rtl/execute_mul_iter.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module mul_iter
  import execute_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic              busy;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc_next;

  // product is the accumulator value that the final iteration will store,
  // so the caller can register it on the same edge the multiply completes.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    done     = busy && (cnt == 6'd63);
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 6'd1;
      if (cnt == 6'd63)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ALU, address generation and iterative multiply feeding memory_access
module execute_stage
  import execute_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  execute_if.slave           dec,
  output logic [BUNDLE_W-1:0] Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
  output logic               illegal_op
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]        state;
  logic [REG_W-1:0]  rd_q;
  logic              accept;
  logic              is_mul;
  logic              is_illegal;
  bundle_t           alu_bundle;
  logic [5:0]        shamt;
  logic [ADDR_W-1:0] eff_addr;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign dec.in_ready = (state == ST_IDLE);
  assign accept       = dec.in_valid && dec.in_ready;
  assign shamt        = dec.b[5:0];
  assign eff_addr     = ADDR_W'(dec.a + dec.imm);
  assign mul_start    = accept && is_mul && !flush;

  always_comb begin
    alu_bundle = '0;
    is_mul     = 1'b0;
    is_illegal = 1'b0;
    case (dec.op)
      OP_NOP:   alu_bundle = '0;
      OP_ADD:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a + dec.b, '0);
      OP_SUB:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a - dec.b, '0);
      OP_AND:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a & dec.b, '0);
      OP_OR:    alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a | dec.b, '0);
      OP_XOR:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a ^ dec.b, '0);
      OP_SLL:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a << shamt, '0);
      OP_SRL:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd, dec.a >> shamt, '0);
      OP_SRA:   alu_bundle = pack_bundle(1'b1, 1'b0, 1'b0, dec.rd,
                                         DATA_W'($signed(dec.a) >>> shamt), '0);
      OP_LOAD:  alu_bundle = pack_bundle(1'b1, 1'b0, 1'b1, dec.rd, '0, eff_addr);
      OP_STORE: alu_bundle = pack_bundle(1'b0, 1'b1, 1'b0, '0, dec.store_data, eff_addr);
      OP_MUL:   is_mul     = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

  mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .kill    (flush),
    .start   (mul_start),
    .a       (dec.a),
    .b       (dec.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Every path that does not produce a result leaves a bubble in the bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_q       <= '0;
      illegal_op <= 1'b0;
      Address_Value_RegAddress_isLoad_isMemWrite_isWrite <= '0;
    end else begin
      illegal_op <= 1'b0;
      Address_Value_RegAddress_isLoad_isMemWrite_isWrite <= '0;
      if (flush) begin
        state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
        if (accept) begin
          if (is_mul) begin
            state <= ST_MUL;
            rd_q  <= dec.rd;
          end else begin
            illegal_op <= is_illegal;
            Address_Value_RegAddress_isLoad_isMemWrite_isWrite <= alu_bundle;
          end
        end
      end else if (mul_done) begin
        state <= ST_IDLE;
        Address_Value_RegAddress_isLoad_isMemWrite_isWrite <=
          pack_bundle(1'b1, 1'b0, 1'b0, rd_q, mul_product, '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed-vector bench for execute_stage
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [78:0] bundle;
  logic        illegal_op;
  int          n_vec;
  int          n_miss;

  execute_if dec ();

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .dec        (dec),
    .Address_Value_RegAddress_isLoad_isMemWrite_isWrite (bundle),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [78:0] exp_b(input logic wr, input logic mw, input logic ld,
                                        input logic [3:0] rg, input logic [63:0] val,
                                        input logic [7:0] ad);
    return {wr, mw, ld, rg, val, ad};
  endfunction

  task automatic check_vec(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] imm,
                       input logic [63:0] sd, input logic [3:0] rd);
    dec.in_valid   = v;
    dec.op         = op;
    dec.a          = a;
    dec.b          = b;
    dec.imm        = imm;
    dec.store_data = sd;
    dec.rd         = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0, '0, 4'd0);
    step();
    step();
    rst = 1'b0;
    check_vec("reset_bundle", bundle, '0);
    check_vec("reset_illegal", 79'(illegal_op), 79'(0));
    check_vec("reset_ready", 79'(dec.in_ready), 79'(1));

    drive(1'b1, 4'd1, 64'd5, 64'd3, '0, '0, 4'd6);
    step();
    check_vec("add", bundle, exp_b(1, 0, 0, 4'd6, 64'd8, 8'd0));
    check_vec("add_ready", 79'(dec.in_ready), 79'(1));

    drive(1'b1, 4'd9, 64'hF0, 64'd0, 64'h21, '0, 4'd2);
    step();
    check_vec("load_wrap", bundle, exp_b(1, 0, 1, 4'd2, 64'd0, 8'h11));

    drive(1'b1, 4'd10, 64'd2, 64'd0, 64'd0, 64'd3, 4'd5);
    step();
    check_vec("store", bundle, exp_b(0, 1, 0, 4'd0, 64'd3, 8'd2));

    drive(1'b1, 4'd8, 64'h8000_0000_0000_0000, 64'd63, '0, '0, 4'd7);
    step();
    check_vec("sra", bundle, exp_b(1, 0, 0, 4'd7, ONES, 8'd0));

    drive(1'b1, 4'd6, 64'h1234, 64'd64, '0, '0, 4'd1);
    step();
    check_vec("sll_64", bundle, exp_b(1, 0, 0, 4'd1, 64'h1234, 8'd0));

    drive(1'b1, 4'd7, 64'hF000_0000_0000_0000, 64'd4, '0, '0, 4'd3);
    step();
    check_vec("srl", bundle, exp_b(1, 0, 0, 4'd3, 64'h0F00_0000_0000_0000, 8'd0));

    drive(1'b1, 4'd13, 64'd1, 64'd1, '0, '0, 4'd4);
    step();
    check_vec("illegal_bubble", bundle, '0);
    check_vec("illegal_pulse", 79'(illegal_op), 79'(1));
    drive(1'b0, 4'd0, '0, '0, '0, '0, 4'd0);
    step();
    check_vec("illegal_clear", 79'(illegal_op), 79'(0));
    check_vec("idle_bubble", bundle, '0);

    drive(1'b1, 4'd1, 64'd10, 64'd20, '0, '0, 4'd1);
    step();
    check_vec("b2b_add", bundle, exp_b(1, 0, 0, 4'd1, 64'd30, 8'd0));
    drive(1'b1, 4'd2, 64'd3, 64'd5, '0, '0, 4'd2);
    step();
    check_vec("b2b_sub", bundle, exp_b(1, 0, 0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'd0));
    drive(1'b1, 4'd5, 64'hF0F0, 64'hFF00, '0, '0, 4'd3);
    step();
    check_vec("b2b_xor", bundle, exp_b(1, 0, 0, 4'd3, 64'h0FF0, 8'd0));

    flush = 1'b1;
    drive(1'b1, 4'd1, 64'd1, 64'd1, '0, '0, 4'd1);
    step();
    flush = 1'b0;
    check_vec("flush_drops_accept", bundle, '0);

    drive(1'b1, 4'd11, 64'd7, ONES, '0, '0, 4'd9);
    step();
    check_vec("mul_start_bubble", bundle, '0);
    check_vec("mul_start_ready", 79'(dec.in_ready), 79'(0));
    drive(1'b1, 4'd1, 64'd1, 64'd1, '0, '0, 4'd3);
    for (int i = 1; i < 64; i++) begin
      step();
      check_vec($sformatf("mul_busy_bubble_%0d", i), bundle, '0);
      check_vec($sformatf("mul_busy_ready_%0d", i), 79'(dec.in_ready), 79'(0));
    end
    step();
    check_vec("mul_product", bundle, exp_b(1, 0, 0, 4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 8'd0));
    check_vec("mul_done_ready", 79'(dec.in_ready), 79'(1));
    step();
    check_vec("add_after_mul", bundle, exp_b(1, 0, 0, 4'd3, 64'd2, 8'd0));

    drive(1'b1, 4'd11, 64'd3, 64'd5, '0, '0, 4'd8);
    step();
    drive(1'b0, 4'd0, '0, '0, '0, '0, 4'd0);
    for (int i = 1; i < 30; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_vec("mul_flush_bubble", bundle, '0);
    check_vec("mul_flush_ready", 79'(dec.in_ready), 79'(1));
    for (int i = 0; i < 40; i++) begin
      step();
      check_vec($sformatf("mul_flush_quiet_%0d", i), bundle, '0);
    end

    drive(1'b1, 4'd11, 64'd3, 64'd5, '0, '0, 4'd8);
    step();
    drive(1'b0, 4'd0, '0, '0, '0, '0, 4'd0);
    for (int i = 1; i < 30; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_vec("mul_rst_bubble", bundle, '0);
    check_vec("mul_rst_ready", 79'(dec.in_ready), 79'(1));
    check_vec("mul_rst_illegal", 79'(illegal_op), 79'(0));
    for (int i = 0; i < 40; i++) begin
      step();
      check_vec($sformatf("mul_rst_quiet_%0d", i), bundle, '0);
    end

    drive(1'b1, 4'd11, 64'd6, 64'd7, '0, '0, 4'd2);
    step();
    drive(1'b0, 4'd0, '0, '0, '0, '0, 4'd0);
    for (int i = 1; i < 64; i++) step();
    step();
    check_vec("mul_small", bundle, exp_b(1, 0, 0, 4'd2, 64'd42, 8'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
